// File: rtl/countdown_timer.sv
// Loadable down-counter timer with one-shot / auto-reload modes, a registered
// terminal-count pulse and a wrapping expiry counter.
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | decrementing once per cycle
// HOLD  | paused by stop, count frozen
// DONE  | one-shot expired, count is 0
module countdown_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic [WIDTH-1:0] expire_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic [WIDTH-1:0] count_nxt, expire_nxt;
  logic             tc_nxt;
  logic             step;

  // State, counters and registered outputs; busy tracks the next state so it
  // lines up with state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      expire_cnt <= ZERO;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      expire_cnt <= expire_nxt;
      tc         <= tc_nxt;
      busy       <= (state_nxt == RUN);
    end
  end

  // Next-state and datapath: load > stop > start > counting. A start that
  // enters RUN from IDLE or HOLD also takes the first decrement that cycle,
  // while a restart from DONE reloads the full period instead.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    expire_nxt = expire_cnt;
    tc_nxt     = 1'b0;
    step       = 1'b0;

    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      expire_nxt = ZERO;
      state_nxt  = IDLE;
    end else if (stop) begin
      if (state == RUN) state_nxt = HOLD;
    end else begin
      unique case (state)
        IDLE: if (start && count != ZERO) step = 1'b1;
        HOLD: if (start) step = 1'b1;
        DONE: begin
          if (start && reload_reg != ZERO) begin
            count_nxt = reload_reg;
            state_nxt = RUN;
          end
        end
        RUN:  step = 1'b1;
        default: state_nxt = IDLE;
      endcase
    end

    if (step) begin
      state_nxt = RUN;
      if (count > ONE) begin
        count_nxt = count - ONE;
      end else if (count == ONE) begin
        tc_nxt     = 1'b1;
        expire_nxt = expire_cnt + ONE;
        if (auto_reload) begin
          count_nxt = reload_reg;
        end else begin
          count_nxt = ZERO;
          state_nxt = DONE;
        end
      end else begin
        // Defensive only: RUN with a zero count has no period to time.
        state_nxt = DONE;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed checks of countdown_timer against a behavioural
// model of the timer rules, plus a 4-bit build for expiry counter wrap.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, start, stop, auto_reload;
  logic [31:0] load_val;
  logic [31:0] count, expire_cnt;
  logic        tc, busy;

  logic        load4, start4, stop4, ar4;
  logic [3:0]  load_val4, count4, expire4;
  logic        tc4, busy4;

  int n_checks = 0;
  int n_fail   = 0;

  // model: phase 0 idle, 1 running, 2 paused, 3 finished
  int          m_ph;
  logic [31:0] m_count, m_reload, m_exp;
  logic        m_tc;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .auto_reload(auto_reload), .count(count), .tc(tc),
    .busy(busy), .expire_cnt(expire_cnt)
  );

  countdown_timer #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .load(load4), .load_val(load_val4), .start(start4),
    .stop(stop4), .auto_reload(ar4), .count(count4), .tc(tc4),
    .busy(busy4), .expire_cnt(expire4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_count = 0; m_reload = 0; m_exp = 0; m_tc = 0;
  endtask

  task automatic model_step(input logic ld, input logic [31:0] lv,
                            input logic st, input logic sp, input logic ar);
    bit counting;
    m_tc = 0;
    if (ld) begin
      m_count = lv; m_reload = lv; m_exp = 0; m_ph = 0;
    end else if (sp) begin
      if (m_ph == 1) m_ph = 2;
    end else if (st && m_ph == 3) begin
      if (m_reload != 0) begin m_count = m_reload; m_ph = 1; end
    end else begin
      counting = (m_ph == 1) || (st && m_ph == 2) || (st && m_ph == 0 && m_count != 0);
      if (counting) begin
        m_ph = 1;
        if (m_count == 1) begin
          m_tc = 1;
          m_exp = m_exp + 1;
          if (ar) m_count = m_reload;
          else begin m_count = 0; m_ph = 3; end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".count"}, count, m_count);
    chk({tag, ".tc"}, 32'(tc), 32'(m_tc));
    chk({tag, ".busy"}, 32'(busy), 32'(m_ph == 1));
    chk({tag, ".expire"}, expire_cnt, m_exp);
  endtask

  // one clock with the given inputs, then model update and full compare
  task automatic tick(input string tag, input logic ld, input logic [31:0] lv,
                      input logic st, input logic sp, input logic ar);
    load = ld; load_val = lv; start = st; stop = sp; auto_reload = ar;
    @(posedge clk);
    model_step(ld, lv, st, sp, ar);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_ticks(input string tag, input int n, input logic ar);
    for (int i = 0; i < n; i++) tick(tag, 0, 0, 0, 0, ar);
  endtask

  initial begin
    rst = 1'b1;
    load = 0; load_val = 0; start = 0; stop = 0; auto_reload = 0;
    load4 = 0; load_val4 = 0; start4 = 0; stop4 = 0; ar4 = 0;
    model_reset();
    #12;
    chk("reset.count", count, 32'd0);
    chk("reset.tc", 32'(tc), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.expire", expire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 4-bit build: reload 1 in auto mode expires every cycle and wraps at 16
    load4 = 1; load_val4 = 4'd1;
    @(posedge clk); #1;
    load4 = 0; start4 = 1; ar4 = 1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      start4 = 0;
      chk("wrap4.expire", 32'(expire4), 32'(k % 16));
      chk("wrap4.tc", 32'(tc4), 32'd1);
    end
    load4 = 1; load_val4 = 4'd0;
    @(posedge clk); #1;
    load4 = 0;

    // one-shot: load 5, start -> 4,3,2,1,0 with tc on the 0 cycle
    tick("os.load", 1, 5, 0, 0, 0);
    tick("os.start", 0, 0, 1, 0, 0);
    chk("os.first", count, 32'd4);
    idle_ticks("os.run", 4, 0);
    chk("os.zero", count, 32'd0);
    chk("os.tc", 32'(tc), 32'd1);
    chk("os.exp", expire_cnt, 32'd1);
    idle_ticks("os.done", 2, 0);
    chk("os.tc_after", 32'(tc), 32'd0);

    // auto-reload period 3 for 10 cycles
    tick("ar.load", 1, 3, 0, 0, 1);
    tick("ar.start", 0, 0, 1, 0, 1);
    idle_ticks("ar.run", 8, 1);
    chk("ar.exp9", expire_cnt, 32'd3);
    idle_ticks("ar.run", 1, 1);

    // pause / resume: hold at 6 for 5 cycles, tc 6 cycles after resume
    tick("pr.load", 1, 10, 0, 0, 0);
    tick("pr.start", 0, 0, 1, 0, 0);
    idle_ticks("pr.run", 3, 0);
    tick("pr.stop", 0, 0, 0, 1, 0);
    idle_ticks("pr.hold", 5, 0);
    chk("pr.held", count, 32'd6);
    tick("pr.resume", 0, 0, 1, 0, 0);
    idle_ticks("pr.run2", 5, 0);
    chk("pr.tc", 32'(tc), 32'd1);

    // edge cases
    tick("ec.load0", 1, 0, 0, 0, 0);
    tick("ec.start0", 0, 0, 1, 0, 0);
    chk("ec.idle", 32'(busy), 32'd0);
    tick("ec.load9", 1, 9, 0, 0, 0);
    tick("ec.start", 0, 0, 1, 0, 0);
    tick("ec.startstop", 0, 0, 1, 1, 0);
    chk("ec.hold", 32'(busy), 32'd0);
    tick("ec.resume", 0, 0, 1, 0, 0);
    chk("ec.seven", count, 32'd7);
    tick("ec.reload2", 1, 2, 0, 0, 0);
    chk("ec.loaded", count, 32'd2);
    idle_ticks("ec.idle2", 3, 0);

    // reload 1 auto mode: continuous tc
    tick("r1.load", 1, 1, 0, 0, 1);
    tick("r1.start", 0, 0, 1, 0, 1);
    idle_ticks("r1.run", 5, 1);
    chk("r1.exp", expire_cnt, 32'd6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic ld, st, sp, ar;
      logic [31:0] lv;
      ld = ($urandom_range(0, 24) == 0);
      lv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 11) == 0);
      ar = ($urandom_range(0, 7) < 5) ? auto_reload : 1'($urandom_range(0, 1));
      tick("rnd", ld, lv, st, sp, ar);
    end

    // async reset between edges mid-run
    tick("rs.load", 1, 20, 0, 0, 0);
    tick("rs.start", 0, 0, 1, 0, 0);
    idle_ticks("rs.run", 3, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rs.count", count, 32'd0);
    chk("rs.tc", 32'(tc), 32'd0);
    chk("rs.busy", 32'(busy), 32'd0);
    chk("rs.expire", expire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick("rs.start_after", 0, 0, 1, 0, 0);
    idle_ticks("rs.idle", 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
